// File: rtl/adv_timer_pkg.sv
// Shared types, defaults and the command-priority resolver for the timer channel sequencer.
package adv_timer_pkg;

  localparam int unsigned DEF_PRESC_BITS = 8;
  localparam int unsigned DEF_REP_BITS   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

  // One resolved action per cycle, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    CMD_NONE       = 3'd0,
    CMD_RESET      = 3'd1,
    CMD_STOP       = 3'd2,
    CMD_EXPIRE     = 3'd3,
    CMD_REPEAT_DEC = 3'd4,
    CMD_START      = 3'd5
  } cmd_e;

  function automatic cmd_e resolve_cmd(
    input state_e state,
    input logic   rst_req,
    input logic   stop_req,
    input logic   start_req,
    input logic   period_end,
    input logic   rep_zero
  );
    if (rst_req)                         return CMD_RESET;
    if (stop_req && state == ST_RUN)     return CMD_STOP;
    if (period_end && state == ST_RUN)   return rep_zero ? CMD_EXPIRE : CMD_REPEAT_DEC;
    if (start_req && state != ST_RUN)    return CMD_START;
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/adv_timer_seq_ctrl_if.sv
// Command, configuration and counter-control signals of one timer channel sequencer.
interface adv_timer_seq_ctrl_if #(
  parameter int unsigned PRESC_BITS = adv_timer_pkg::DEF_PRESC_BITS,
  parameter int unsigned REP_BITS   = adv_timer_pkg::DEF_REP_BITS
);

  logic                  cmd_start_i;
  logic                  cmd_stop_i;
  logic                  cmd_update_i;
  logic                  cmd_reset_i;
  logic [PRESC_BITS-1:0] cfg_presc_i;
  logic                  cfg_oneshot_i;
  logic [REP_BITS-1:0]   cfg_repeat_i;
  logic                  in_evt_i;
  logic                  counter_end_i;

  logic                  ctrl_active_o;
  logic                  ctrl_update_o;
  logic                  ctrl_rst_o;
  logic                  counter_event_o;
  logic                  done_o;
  logic                  busy_o;
  logic [REP_BITS-1:0]   repeat_cnt_o;

  modport master (
    output cmd_start_i, cmd_stop_i, cmd_update_i, cmd_reset_i,
    output cfg_presc_i, cfg_oneshot_i, cfg_repeat_i,
    output in_evt_i, counter_end_i,
    input  ctrl_active_o, ctrl_update_o, ctrl_rst_o, counter_event_o,
    input  done_o, busy_o, repeat_cnt_o
  );

  modport slave (
    input  cmd_start_i, cmd_stop_i, cmd_update_i, cmd_reset_i,
    input  cfg_presc_i, cfg_oneshot_i, cfg_repeat_i,
    input  in_evt_i, counter_end_i,
    output ctrl_active_o, ctrl_update_o, ctrl_rst_o, counter_event_o,
    output done_o, busy_o, repeat_cnt_o
  );

endinterface

// File: rtl/adv_timer_prescaler.sv
// Event prescaler: divides qualified input events by (divide+1) with a shadowed divide value.
module adv_timer_prescaler #(
  parameter int unsigned PRESC_BITS = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load_now,
  input  logic                  evt,
  input  logic                  upd,
  input  logic [PRESC_BITS-1:0] cfg,
  output logic                  strobe
);

  logic [PRESC_BITS-1:0] cnt;
  logic [PRESC_BITS-1:0] div_active;
  logic [PRESC_BITS-1:0] div_shadow;
  logic                  pending;
  logic                  step;
  logic                  wrap;

  assign step = en && evt;
  assign wrap = step && (cnt == div_active);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, and all of it is cleared by the asynchronous reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt        <= '0;
      div_active <= '0;
      div_shadow <= '0;
      pending    <= 1'b0;
      strobe     <= 1'b0;
    end else begin
      strobe <= wrap;

      if (clr) begin
        cnt <= '0;
      end else if (step) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
      end

      // A running timer only picks up a new divide at a period boundary, so no period is cut short.
      if (upd && load_now) begin
        div_active <= cfg;
        div_shadow <= cfg;
        pending    <= 1'b0;
      end else begin
        if (wrap && pending) begin
          div_active <= div_shadow;
          pending    <= 1'b0;
        end
        if (upd) begin
          div_shadow <= cfg;
          pending    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adv_timer_seq_ctrl.sv
// Channel sequencer: turns register-file command pulses into counter controls, with prescaling and one-shot repeat.
module adv_timer_seq_ctrl
  import adv_timer_pkg::*;
#(
  parameter int unsigned PRESC_BITS = DEF_PRESC_BITS,
  parameter int unsigned REP_BITS   = DEF_REP_BITS
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  adv_timer_seq_ctrl_if.slave  bus
);

  state_e              state;
  cmd_e                cmd;
  logic [REP_BITS-1:0] rep_cnt;
  logic                period_end;
  logic                rep_zero;
  logic                presc_en;
  logic                presc_clr;
  logic                presc_load_now;

  assign period_end = bus.counter_end_i && bus.cfg_oneshot_i;
  assign rep_zero   = (rep_cnt == '0);

  assign cmd = resolve_cmd(state, bus.cmd_reset_i, bus.cmd_stop_i, bus.cmd_start_i,
                           period_end, rep_zero);

  // Count only when the timer stays in RUN this cycle, so a strobe never lands while inactive.
  assign presc_en       = (state == ST_RUN) && ((cmd == CMD_NONE) || (cmd == CMD_REPEAT_DEC));
  assign presc_clr      = (cmd == CMD_RESET) || ((cmd == CMD_START) && (state == ST_IDLE));
  assign presc_load_now = (state != ST_RUN);
  assign bus.repeat_cnt_o = rep_cnt;

  adv_timer_prescaler #(
    .PRESC_BITS (PRESC_BITS)
  ) u_presc (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .en       (presc_en),
    .clr      (presc_clr),
    .load_now (presc_load_now),
    .evt      (bus.in_evt_i),
    .upd      (bus.cmd_update_i),
    .cfg      (bus.cfg_presc_i),
    .strobe   (bus.counter_event_o)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state             <= ST_IDLE;
      rep_cnt           <= '0;
      bus.ctrl_active_o <= 1'b0;
      bus.ctrl_update_o <= 1'b0;
      bus.ctrl_rst_o    <= 1'b0;
      bus.done_o        <= 1'b0;
      bus.busy_o        <= 1'b0;
    end else begin
      bus.ctrl_rst_o    <= (cmd == CMD_RESET);
      bus.ctrl_update_o <= bus.cmd_update_i;
      bus.done_o        <= (cmd == CMD_EXPIRE);

      unique case (cmd)
        CMD_RESET: begin
          state             <= ST_IDLE;
          rep_cnt           <= bus.cfg_repeat_i;
          bus.ctrl_active_o <= 1'b0;
          bus.busy_o        <= 1'b0;
        end
        CMD_STOP: begin
          state             <= ST_PAUSED;
          bus.ctrl_active_o <= 1'b0;
          bus.busy_o        <= 1'b1;
        end
        CMD_EXPIRE: begin
          state             <= ST_IDLE;
          bus.ctrl_active_o <= 1'b0;
          bus.busy_o        <= 1'b0;
        end
        CMD_REPEAT_DEC: begin
          rep_cnt <= rep_cnt - 1'b1;
        end
        CMD_START: begin
          // A fresh start reloads the repeat budget; a resume keeps what was left.
          if (state == ST_IDLE) begin
            rep_cnt <= bus.cfg_repeat_i;
          end
          state             <= ST_RUN;
          bus.ctrl_active_o <= 1'b1;
          bus.busy_o        <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adv_timer_seq_ctrl.sv
// Directed bench for adv_timer_seq_ctrl with a cycle-level behavioural model and per-cycle comparison.
module tb_adv_timer_seq_ctrl;

  localparam int unsigned PB          = 8;
  localparam int unsigned PRESC_RANGE = 1 << PB;
  localparam int S_IDLE   = 0;
  localparam int S_RUN    = 1;
  localparam int S_PAUSED = 2;

  logic clk;
  logic rstn;
  int   n_checks = 0;
  int   n_errors = 0;

  adv_timer_seq_ctrl_if b ();

  adv_timer_seq_ctrl dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int          state;
    int unsigned rep;
    int unsigned cnt;
    int unsigned div;
    int unsigned shadow;
    bit          pending;
    bit          active;
    bit          update;
    bit          rst;
    bit          evt;
    bit          done;
    bit          busy;
  } model_t;

  model_t m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Next-cycle expectations derived from the command rules, evaluated on the inputs seen at a clock edge.
  function automatic model_t model_next(input model_t c);
    model_t n;
    bit running, period_end, expires, counts, wraps;
    n          = c;
    running    = (c.state == S_RUN);
    period_end = running && b.counter_end_i && b.cfg_oneshot_i;
    expires    = period_end && (c.rep == 0);
    counts     = running && b.in_evt_i && !b.cmd_stop_i && !b.cmd_reset_i && !expires;
    wraps      = counts && (c.cnt == c.div);
    n.rst    = b.cmd_reset_i;
    n.update = b.cmd_update_i;
    n.done   = 1'b0;
    n.evt    = wraps;
    if (b.cmd_reset_i) begin
      n.state = S_IDLE;
      n.rep   = b.cfg_repeat_i;
      n.cnt   = 0;
    end else if (b.cmd_stop_i && running) begin
      n.state = S_PAUSED;
    end else if (period_end) begin
      if (expires) begin
        n.state = S_IDLE;
        n.done  = 1'b1;
      end else begin
        n.rep = c.rep - 1;
      end
    end else if (b.cmd_start_i && !running) begin
      if (c.state == S_IDLE) begin
        n.rep = b.cfg_repeat_i;
        n.cnt = 0;
      end
      n.state = S_RUN;
    end
    if (counts) n.cnt = wraps ? 0 : (c.cnt + 1) % PRESC_RANGE;
    if (b.cmd_update_i && !running) begin
      n.div     = b.cfg_presc_i;
      n.shadow  = b.cfg_presc_i;
      n.pending = 1'b0;
    end else begin
      if (wraps && c.pending) begin
        n.div     = c.shadow;
        n.pending = 1'b0;
      end
      if (b.cmd_update_i) begin
        n.shadow  = b.cfg_presc_i;
        n.pending = 1'b1;
      end
    end
    n.active = (n.state == S_RUN);
    n.busy   = (n.state != S_IDLE);
    return n;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) m <= '0;
    else       m <= model_next(m);
  end

  always @(negedge clk) begin
    check("cmp_active", b.ctrl_active_o,   m.active);
    check("cmp_update", b.ctrl_update_o,   m.update);
    check("cmp_rst",    b.ctrl_rst_o,      m.rst);
    check("cmp_event",  b.counter_event_o, m.evt);
    check("cmp_done",   b.done_o,          m.done);
    check("cmp_busy",   b.busy_o,          m.busy);
    check("cmp_repeat", b.repeat_cnt_o,    m.rep);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();  b.cmd_start_i  = 1'b1; tick(); b.cmd_start_i  = 1'b0; endtask
  task automatic pulse_stop();   b.cmd_stop_i   = 1'b1; tick(); b.cmd_stop_i   = 1'b0; endtask
  task automatic pulse_update(); b.cmd_update_i = 1'b1; tick(); b.cmd_update_i = 1'b0; endtask
  task automatic pulse_reset();  b.cmd_reset_i  = 1'b1; tick(); b.cmd_reset_i  = 1'b0; endtask
  task automatic pulse_end();    b.counter_end_i = 1'b1; tick(); b.counter_end_i = 1'b0; endtask

  initial begin
    int strobes;
    int first;
    logic [11:0] pattern;

    rstn            = 1'b0;
    b.cmd_start_i   = 1'b0;
    b.cmd_stop_i    = 1'b0;
    b.cmd_update_i  = 1'b0;
    b.cmd_reset_i   = 1'b0;
    b.cfg_presc_i   = '0;
    b.cfg_oneshot_i = 1'b0;
    b.cfg_repeat_i  = '0;
    b.in_evt_i      = 1'b0;
    b.counter_end_i = 1'b0;
    tick(); tick();
    check("rst_active", b.ctrl_active_o, 0);
    check("rst_busy",   b.busy_o, 0);
    check("rst_repeat", b.repeat_cnt_o, 0);
    rstn = 1'b1;
    tick();

    // Divide-by-4 run with an event every cycle.
    b.cfg_presc_i = 8'd3;
    pulse_update();
    check("t1_update_pulse", b.ctrl_update_o, 1);
    pulse_start();
    check("t1_active", b.ctrl_active_o, 1);
    check("t1_busy",   b.busy_o, 1);
    b.in_evt_i = 1'b1;
    strobes = 0; first = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (b.counter_event_o) begin
        strobes++;
        if (first == 0) first = i;
      end
    end
    b.in_evt_i = 1'b0;
    check("t1_strobe_count", strobes, 3);
    check("t1_first_strobe", first, 4);

    // One-shot with two extra periods.
    b.cfg_oneshot_i = 1'b1;
    b.cfg_repeat_i  = 8'd2;
    pulse_reset();
    check("t2_ctrl_rst", b.ctrl_rst_o, 1);
    pulse_start();
    check("t2_repeat_2", b.repeat_cnt_o, 2);
    pulse_end();
    check("t2_repeat_1", b.repeat_cnt_o, 1);
    tick();
    pulse_end();
    check("t2_repeat_0", b.repeat_cnt_o, 0);
    check("t2_still_run", b.ctrl_active_o, 1);
    tick();
    pulse_end();
    check("t2_done", b.done_o, 1);
    check("t2_inactive", b.ctrl_active_o, 0);
    check("t2_idle", b.busy_o, 0);
    tick();
    check("t2_done_single", b.done_o, 0);

    // Pause with two events already counted, then resume.
    b.cfg_oneshot_i = 1'b0;
    b.cfg_presc_i   = 8'd5;
    pulse_update();
    pulse_start();
    b.in_evt_i = 1'b1;
    tick(); tick();
    b.in_evt_i = 1'b0;
    pulse_stop();
    check("t3_paused_inactive", b.ctrl_active_o, 0);
    check("t3_paused_busy", b.busy_o, 1);
    b.in_evt_i = 1'b1;
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (b.counter_event_o) strobes++;
    end
    b.in_evt_i = 1'b0;
    check("t3_no_strobe_paused", strobes, 0);
    pulse_start();
    check("t3_resumed", b.ctrl_active_o, 1);
    b.in_evt_i = 1'b1;
    first = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (b.counter_event_o && first == 0) first = i;
    end
    b.in_evt_i = 1'b0;
    check("t3_first_after_resume", first, 4);

    // Simultaneous commands.
    b.cmd_stop_i = 1'b1;
    pulse_start();
    b.cmd_stop_i = 1'b0;
    check("t4_start_stop_paused", b.ctrl_active_o, 0);
    check("t4_start_stop_busy", b.busy_o, 1);
    b.cfg_oneshot_i = 1'b1;
    b.cfg_repeat_i  = 8'd0;
    pulse_reset();
    pulse_start();
    b.counter_end_i = 1'b1;
    pulse_reset();
    b.counter_end_i = 1'b0;
    check("t4_rst_wins", b.ctrl_rst_o, 1);
    check("t4_no_done", b.done_o, 0);
    check("t4_idle", b.busy_o, 0);

    // Divide change while running waits for the current period to finish.
    b.cfg_oneshot_i = 1'b0;
    b.cfg_presc_i   = 8'd1;
    pulse_update();
    pulse_start();
    b.cfg_presc_i = 8'd4;
    pattern = '0;
    for (int i = 1; i <= 12; i++) begin
      b.in_evt_i = 1'b1;
      if (i == 1) b.cmd_update_i = 1'b1;
      tick();
      if (i == 1) begin
        check("t5_update_pulse", b.ctrl_update_o, 1);
        b.cmd_update_i = 1'b0;
      end
      pattern[i-1] = b.counter_event_o;
    end
    check("t5_strobe_pattern", pattern, 12'h842);

    // Asynchronous reset while running.
    check("t6_running", b.ctrl_active_o, 1);
    #2 rstn = 1'b0;
    #1;
    check("t6_async_active", b.ctrl_active_o, 0);
    check("t6_async_busy", b.busy_o, 0);
    check("t6_async_event", b.counter_event_o, 0);
    check("t6_async_done", b.done_o, 0);
    tick(); tick();
    rstn = 1'b1;
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (b.counter_event_o) strobes++;
    end
    check("t6_no_strobe_idle", strobes, 0);
    check("t6_idle_busy", b.busy_o, 0);
    pulse_start();
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (b.counter_event_o) strobes++;
    end
    b.in_evt_i = 1'b0;
    check("t6_divide_reset_to_1", strobes, 3);

    // Full-width divide: all-ones wraps after 256 events.
    pulse_reset();
    b.cfg_presc_i = 8'hFF;
    pulse_update();
    pulse_start();
    b.in_evt_i = 1'b1;
    strobes = 0; first = 0;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (b.counter_event_o) begin
        strobes++;
        if (first == 0) first = i;
      end
    end
    b.in_evt_i = 1'b0;
    check("t7_full_width_count", strobes, 1);
    check("t7_full_width_first", first, 256);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
